// File: rtl/sc_progress_pkg.sv
// Shared definitions for the level-progress tracker: state encoding and default sizing.
package sc_progress_pkg;

    localparam int NESTS_DEFAULT      = 5;
    localparam int LIVES_INIT_DEFAULT = 3;
    localparam int LIVES_MAX_DEFAULT  = 7;
    localparam int HOLDOFF_DEFAULT    = 4;
    localparam int LIVES_W            = 3;

    localparam logic [1:0] ST_PLAY       = 2'd0;
    localparam logic [1:0] ST_RESPAWN    = 2'd1;
    localparam logic [1:0] ST_LEVEL_DONE = 2'd2;
    localparam logic [1:0] ST_GAME_OVER  = 2'd3;

    typedef enum logic [1:0] {
        PLAY       = ST_PLAY,
        RESPAWN    = ST_RESPAWN,
        LEVEL_DONE = ST_LEVEL_DONE,
        GAME_OVER  = ST_GAME_OVER
    } state_e;

endpackage

// File: rtl/sc_progress_holdoff.sv
// RESPAWN hold-off counter: counts 0..HOLDOFF-1 after start, pulses done on the final count.
module sc_progress_holdoff
    import sc_progress_pkg::*;
#(
    parameter int HOLDOFF = HOLDOFF_DEFAULT
) (
    input  logic clk,
    input  logic rst,
    input  logic start,
    input  logic abort,
    output logic done
);

    localparam int CW = (HOLDOFF > 1) ? $clog2(HOLDOFF) : 1;
    localparam logic [CW-1:0] LAST = CW'(HOLDOFF - 1);

    logic          active_q, active_d;
    logic [CW-1:0] cnt_q, cnt_d;

    always_comb begin
        active_d = active_q;
        cnt_d    = cnt_q;
        if (abort) begin
            active_d = 1'b0;
            cnt_d    = '0;
        end else if (start) begin
            active_d = 1'b1;
            cnt_d    = '0;
        end else if (active_q) begin
            if (cnt_q == LAST) begin
                active_d = 1'b0;
                cnt_d    = '0;
            end else begin
                cnt_d = cnt_q + CW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            active_q <= 1'b0;
            cnt_q    <= '0;
        end else begin
            active_q <= active_d;
            cnt_q    <= cnt_d;
        end
    end

    assign done = active_q && (cnt_q == LAST);

endmodule

// File: rtl/sc_statemachine_progress.sv
// Level-progress tracker: nest occupancy, lives and active-low status strobes for the main FSM.
// Optional: SC_STATEMACHINE_PROGRESS_BONUS_LIFE_EN grants one life on level completion.
module sc_statemachine_progress
    import sc_progress_pkg::*;
#(
    parameter int NESTS      = NESTS_DEFAULT,
    parameter int LIVES_INIT = LIVES_INIT_DEFAULT,
    parameter int LIVES_MAX  = LIVES_MAX_DEFAULT,
    parameter int HOLDOFF    = HOLDOFF_DEFAULT
) (
    input  logic               SC_STATEMACHINE_PROGRESS_CLOCK_50,
    input  logic               SC_STATEMACHINE_PROGRESS_RESET_InHigh,
    input  logic               SC_STATEMACHINE_PROGRESS_load_InLow,
    input  logic               SC_STATEMACHINE_PROGRESS_changeLevel_InLow,
    input  logic [NESTS-1:0]   SC_STATEMACHINE_PROGRESS_nestHit_InBUS,
    input  logic               SC_STATEMACHINE_PROGRESS_collision_InLow,
    output logic               SC_STATEMACHINE_PROGRESS_nidosCompletos_OutLow,
    output logic               SC_STATEMACHINE_PROGRESS_PerdioVidas_OutLow,
    output logic               SC_STATEMACHINE_PROGRESS_respawn_OutLow,
    output logic [NESTS-1:0]   SC_STATEMACHINE_PROGRESS_nests_OutBUS,
    output logic [LIVES_W-1:0] SC_STATEMACHINE_PROGRESS_lives_OutBUS
);

    logic clk, rst, load_n, change_n, coll_n;
    logic [NESTS-1:0] nest_hit;

    assign clk      = SC_STATEMACHINE_PROGRESS_CLOCK_50;
    assign rst      = SC_STATEMACHINE_PROGRESS_RESET_InHigh;
    assign load_n   = SC_STATEMACHINE_PROGRESS_load_InLow;
    assign change_n = SC_STATEMACHINE_PROGRESS_changeLevel_InLow;
    assign coll_n   = SC_STATEMACHINE_PROGRESS_collision_InLow;
    assign nest_hit = SC_STATEMACHINE_PROGRESS_nestHit_InBUS;

    function automatic logic [NESTS-1:0] lowest_bit(input logic [NESTS-1:0] v);
        return v & (~v + NESTS'(1));
    endfunction

    state_e             state_q, state_d;
    logic [LIVES_W-1:0] lives_q, lives_d;
    logic [NESTS-1:0]   nests_q, nests_d;
    logic [NESTS-1:0]   hit;
    logic               hold_start, hold_done;

    assign hit = lowest_bit(nest_hit);

    always_comb begin
        state_d = state_q;
        lives_d = lives_q;
        nests_d = nests_q;
        if (!load_n) begin
            state_d = PLAY;
            lives_d = LIVES_W'(LIVES_INIT);
            nests_d = '0;
        end else begin
            if (!change_n) begin
                nests_d = '0;
            end
            // The hold-off keeps running through a level change so RESPAWN can never stall.
            unique case (state_q)
                PLAY: begin
                    if (change_n) begin
                        if (!coll_n || ((hit & nests_q) != '0)) begin
                            if (lives_q <= LIVES_W'(1)) begin
                                lives_d = '0;
                                state_d = GAME_OVER;
                            end else begin
                                lives_d = lives_q - LIVES_W'(1);
                                state_d = RESPAWN;
                            end
                        end else if (hit != '0) begin
                            nests_d = nests_q | hit;
                            if ((nests_q | hit) == {NESTS{1'b1}}) begin
                                state_d = LEVEL_DONE;
`ifdef SC_STATEMACHINE_PROGRESS_BONUS_LIFE_EN
                                if (lives_q < LIVES_W'(LIVES_MAX)) begin
                                    lives_d = lives_q + LIVES_W'(1);
                                end
`endif
                            end else begin
                                state_d = RESPAWN;
                            end
                        end
                    end
                end
                RESPAWN: begin
                    if (hold_done) begin
                        state_d = PLAY;
                    end
                end
                LEVEL_DONE: begin
                    if (!change_n) begin
                        state_d = PLAY;
                    end
                end
                GAME_OVER: begin
                    state_d = GAME_OVER;
                end
            endcase
        end
    end

    assign hold_start = (state_d == RESPAWN) && (state_q != RESPAWN);

    sc_progress_holdoff #(
        .HOLDOFF(HOLDOFF)
    ) u_holdoff (
        .clk  (clk),
        .rst  (rst),
        .start(hold_start),
        .abort(!load_n),
        .done (hold_done)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= PLAY;
            lives_q <= LIVES_W'(LIVES_INIT);
            nests_q <= '0;
        end else begin
            state_q <= state_d;
            lives_q <= lives_d;
            nests_q <= nests_d;
        end
    end

    assign SC_STATEMACHINE_PROGRESS_nidosCompletos_OutLow = (state_q != LEVEL_DONE);
    assign SC_STATEMACHINE_PROGRESS_PerdioVidas_OutLow    = (state_q != GAME_OVER);
    assign SC_STATEMACHINE_PROGRESS_respawn_OutLow        = (state_q != RESPAWN);
    assign SC_STATEMACHINE_PROGRESS_nests_OutBUS          = nests_q;
    assign SC_STATEMACHINE_PROGRESS_lives_OutBUS          = lives_q;

endmodule

// File: tb/tb_sc_statemachine_progress.sv
// Directed bench for sc_statemachine_progress with a behavioural progress model checked every cycle.
module tb_sc_statemachine_progress;

    logic       clk = 1'b0;
    logic       rst;
    logic       load_n, chg_n, coll_n;
    logic [4:0] nest_hit;
    logic       nidos_n, perdio_n, respawn_n;
    logic [4:0] nests;
    logic [2:0] lives;

    int checks = 0;
    int errors = 0;
    bit model_on = 1'b0;

`ifdef SC_STATEMACHINE_PROGRESS_BONUS_LIFE_EN
    localparam int LIVES_AFTER_LEVEL = 4;
`else
    localparam int LIVES_AFTER_LEVEL = 3;
`endif

    always #5 clk = ~clk;

    sc_statemachine_progress dut (
        .SC_STATEMACHINE_PROGRESS_CLOCK_50             (clk),
        .SC_STATEMACHINE_PROGRESS_RESET_InHigh         (rst),
        .SC_STATEMACHINE_PROGRESS_load_InLow           (load_n),
        .SC_STATEMACHINE_PROGRESS_changeLevel_InLow    (chg_n),
        .SC_STATEMACHINE_PROGRESS_nestHit_InBUS        (nest_hit),
        .SC_STATEMACHINE_PROGRESS_collision_InLow      (coll_n),
        .SC_STATEMACHINE_PROGRESS_nidosCompletos_OutLow(nidos_n),
        .SC_STATEMACHINE_PROGRESS_PerdioVidas_OutLow   (perdio_n),
        .SC_STATEMACHINE_PROGRESS_respawn_OutLow       (respawn_n),
        .SC_STATEMACHINE_PROGRESS_nests_OutBUS         (nests),
        .SC_STATEMACHINE_PROGRESS_lives_OutBUS         (lives)
    );

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Model: phase 0 playing, 1 respawning, 2 level complete, 3 out of lives.
    int         m_lives = 3;
    logic [4:0] m_nests = 5'b0;
    int         m_phase = 0;
    int         m_hold  = 0;

    always @(posedge clk) begin
        int         l, ph, h;
        logic [4:0] n, one;
        l = m_lives; n = m_nests; ph = m_phase; h = m_hold;
        one = 5'b0;
        for (int i = 4; i >= 0; i--) if (nest_hit[i]) one = 5'b00001 << i;
        if (rst || !load_n) begin
            l = 3; n = 5'b0; ph = 0; h = 0;
        end else if (!chg_n) begin
            n = 5'b0;
            if (ph == 2) ph = 0;
            else if (ph == 1) begin
                h = h - 1;
                if (h == 0) ph = 0;
            end
        end else if (ph == 0) begin
            if (!coll_n || ((one & m_nests) != 5'b0)) begin
                if (l <= 1) begin l = 0; ph = 3; end
                else begin l = l - 1; ph = 1; h = 4; end
            end else if (one != 5'b0) begin
                n = m_nests | one;
                if (n == 5'b11111) begin
                    ph = 2;
`ifdef SC_STATEMACHINE_PROGRESS_BONUS_LIFE_EN
                    if (l < 7) l = l + 1;
`endif
                end else begin
                    ph = 1; h = 4;
                end
            end
        end else if (ph == 1) begin
            h = h - 1;
            if (h == 0) ph = 0;
        end
        m_lives <= l; m_nests <= n; m_phase <= ph; m_hold <= h;
    end

    always @(negedge clk) begin
        if (model_on) begin
            chk("model_lives", int'(lives), m_lives);
            chk("model_nests", int'(nests), int'(m_nests));
            chk("model_respawn", int'(respawn_n), int'(m_phase != 1));
            chk("model_nidos", int'(nidos_n), int'(m_phase != 2));
            chk("model_perdio", int'(perdio_n), int'(m_phase != 3));
        end
    end

    task automatic idle();
        load_n = 1'b1; chg_n = 1'b1; coll_n = 1'b1; nest_hit = 5'b0;
    endtask

    task automatic pulse(input logic ld, input logic cl, input logic [4:0] hit, input logic co);
        load_n = ld; chg_n = cl; nest_hit = hit; coll_n = co;
        @(negedge clk);
        idle();
    endtask

    initial begin
        int cnt;
        rst = 1'b1;
        idle();
        repeat (2) @(negedge clk);
        chk("reset_lives", int'(lives), 3);
        chk("reset_nests", int'(nests), 0);
        chk("reset_strobes", int'({nidos_n, perdio_n, respawn_n}), 7);
        rst = 1'b0;
        model_on = 1'b1;

        for (int i = 0; i < 5; i++) begin
            pulse(1'b1, 1'b1, 5'(1 << i), 1'b1);
            if (i < 4) begin
                cnt = 0;
                repeat (8) begin
                    if (!respawn_n) cnt++;
                    @(negedge clk);
                end
                chk("respawn_len", cnt, 4);
            end
        end
        chk("level_nests", int'(nests), 31);
        chk("level_nidos", int'(nidos_n), 0);
        repeat (3) @(negedge clk);
        chk("level_nidos_held", int'(nidos_n), 0);
        pulse(1'b1, 1'b0, 5'b0, 1'b1);
        chk("chg_nests", int'(nests), 0);
        chk("chg_nidos", int'(nidos_n), 1);
        chk("chg_lives", int'(lives), LIVES_AFTER_LEVEL);

        pulse(1'b0, 1'b1, 5'b0, 1'b1);
        chk("load_lives", int'(lives), 3);
        for (int k = 0; k < 3; k++) begin
            pulse(1'b1, 1'b1, 5'b0, 1'b0);
            chk("coll_lives", int'(lives), 2 - k);
            repeat (6) @(negedge clk);
        end
        chk("over_perdio", int'(perdio_n), 0);
        pulse(1'b1, 1'b0, 5'b0, 1'b1);
        chk("over_chg_perdio", int'(perdio_n), 0);
        pulse(1'b1, 1'b1, 5'b0, 1'b0);
        chk("over_floor_lives", int'(lives), 0);
        pulse(1'b0, 1'b1, 5'b0, 1'b1);
        chk("restart_lives", int'(lives), 3);
        chk("restart_perdio", int'(perdio_n), 1);

        pulse(1'b1, 1'b1, 5'b00100, 1'b0);
        chk("simul_lives", int'(lives), 2);
        chk("simul_nests", int'(nests), 0);
        chk("simul_respawn", int'(respawn_n), 0);
        repeat (6) @(negedge clk);

        pulse(1'b0, 1'b1, 5'b0, 1'b1);
        pulse(1'b1, 1'b1, 5'b00010, 1'b1);
        repeat (6) @(negedge clk);
        pulse(1'b1, 1'b1, 5'b00010, 1'b1);
        chk("occupied_lives", int'(lives), 2);
        chk("occupied_nests", int'(nests), 2);
        repeat (6) @(negedge clk);

        pulse(1'b0, 1'b1, 5'b0, 1'b1);
        pulse(1'b1, 1'b1, 5'b0, 1'b0);
        chk("abort_pre_respawn", int'(respawn_n), 0);
        @(negedge clk);
        pulse(1'b0, 1'b1, 5'b0, 1'b1);
        chk("abort_respawn", int'(respawn_n), 1);
        chk("abort_lives", int'(lives), 3);

        pulse(1'b1, 1'b1, 5'b0, 1'b0);
        pulse(1'b1, 1'b1, 5'b0, 1'b0);
        chk("ignore_lives", int'(lives), 2);
        chk("ignore_respawn", int'(respawn_n), 0);
        repeat (6) @(negedge clk);
        chk("ignore_done", int'(respawn_n), 1);

        pulse(1'b0, 1'b1, 5'b0, 1'b1);
        pulse(1'b1, 1'b1, 5'b10100, 1'b1);
        chk("multihot_nests", int'(nests), 4);
        repeat (6) @(negedge clk);

        model_on = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/sc_statemachine_progress.md
# sc_statemachine_progress

Level-progress tracker directly upstream of the main game state machine. It tracks per-level nest occupancy and the remaining lives. It produces the two active-low status inputs the main machine branches on: nests complete and lives lost. It consumes that machine's active-low `load` and `changeLevel` strobes to restart the game or advance a level. It also drives a respawn strobe and the occupancy and lives buses for the display path.

## Interface
- `NESTS`, 5: number of nests per level; width of the occupancy buses.
- `LIVES_INIT`, 3: lives loaded on reset and on `load`.
- `LIVES_MAX`, 7: saturation ceiling for the lives counter; lives bus width is 3.
- `HOLDOFF`, 4: length of the RESPAWN state in cycles; must be 1 or more.
- `SC_STATEMACHINE_PROGRESS_CLOCK_50`, input, 1: the single clock. All state is updated on its rising edge.
- `SC_STATEMACHINE_PROGRESS_RESET_InHigh`, input, 1: reset, synchronous and active-high.
- `SC_STATEMACHINE_PROGRESS_load_InLow`, input, 1: new game. Reloads lives and clears nests.
- `SC_STATEMACHINE_PROGRESS_changeLevel_InLow`, input, 1: level change. Clears nests and keeps lives.
- `SC_STATEMACHINE_PROGRESS_nestHit_InBUS`, input, NESTS: one-hot strobe; the player entered nest i this cycle.
- `SC_STATEMACHINE_PROGRESS_collision_InLow`, input, 1: the player was hit this cycle.
- `SC_STATEMACHINE_PROGRESS_nidosCompletos_OutLow`, output, 1: low while in LEVEL_DONE.
- `SC_STATEMACHINE_PROGRESS_PerdioVidas_OutLow`, output, 1: low while in GAME_OVER.
- `SC_STATEMACHINE_PROGRESS_respawn_OutLow`, output, 1: low while in RESPAWN.
- `SC_STATEMACHINE_PROGRESS_nests_OutBUS`, output, NESTS: occupancy mask; bit i set means nest i is filled.
- `SC_STATEMACHINE_PROGRESS_lives_OutBUS`, output, 3: remaining lives.

## Operation
- States: PLAY, RESPAWN, LEVEL_DONE, GAME_OVER.
- All outputs are Moore outputs, decoded from registered state and registered counters.
- Reset gives: state PLAY, lives = LIVES_INIT, nests = 0, holdoff counter = 0. The three strobes are high, the nests bus is 0, and the lives bus is LIVES_INIT.
- Priority, highest first:
  1. reset
  2. `load` low
  3. `changeLevel` low
  4. collision
  5. nest hit
- `load` low, in any state: lives = LIVES_INIT, nests = 0, state PLAY, counter = 0.
- `changeLevel` low:
  - nests = 0.
  - LEVEL_DONE goes to PLAY.
  - GAME_OVER stays in GAME_OVER; only `load` exits it.
  - RESPAWN and PLAY keep their state.
- PLAY, collision low, or a hit on an already-occupied nest:
  - if lives ≤ 1, lives = 0 and the state goes to GAME_OVER;
  - otherwise lives decrements by 1 and the state goes to RESPAWN.
- PLAY, hit on a free nest (no collision):
  - the nest bit is set;
  - if the mask is now all ones, the state goes to LEVEL_DONE;
  - otherwise the state goes to RESPAWN.
- Multi-hot `nestHit`: only the lowest set bit is used.
- RESPAWN: the counter counts from 0 to HOLDOFF-1, then the state goes to PLAY and the counter clears. Collision and nest-hit inputs are ignored.
- LEVEL_DONE and GAME_OVER ignore collision and nest hits.

## Timing
- Event-to-output latency is 1 cycle: an event sampled at edge k shows on the outputs after edge k.
- Handshake with the main FSM:
  - `nidosCompletos` stays low until the `changeLevel` low is sampled, then goes high on the next edge.
  - `PerdioVidas` stays low until the `load` low is sampled.
  - Holding at level, not pulsing, guarantees the main FSM sees the condition in whichever cycle it polls.
- RESPAWN lasts exactly HOLDOFF cycles, so `respawn_OutLow` is low for HOLDOFF cycles.
- Lives never wrap below 0 or above LIVES_MAX.
- `load` mid-RESPAWN aborts the hold-off immediately; the next cycle is PLAY.

## Configuration
- `SC_STATEMACHINE_PROGRESS_BONUS_LIFE_EN`:
  - Defined: on entry to LEVEL_DONE, lives increments by 1, saturating at LIVES_MAX, in the same edge as the final nest bit is set.
  - Undefined: lives is unchanged by level completion.

## Structure
- Shared package `sc_progress_pkg` holds:
  - the state encoding localparams (PLAY=0, RESPAWN=1, LEVEL_DONE=2, GAME_OVER=3, 2-bit);
  - the defaults NESTS, LIVES_INIT, LIVES_MAX, HOLDOFF;
  - the 3-bit lives width.
- One sub-module, `sc_progress_holdoff`, implements the RESPAWN counter:
  - inputs: start, abort;
  - output: done, a 1-cycle high on the final count.
  - The top-level FSM instantiates it.
- Lowest-set-bit isolation of `nestHit` is a local function in the top module.

## Test plan
- Reset: hold reset 2 cycles → lives=3, nests=0, all strobes high, state PLAY.
- Nest fill: 5 hits on nests 0..4, spaced by more than HOLDOFF cycles → respawn low for 4 cycles after each of the first four hits. After hit 5, nests=5'b11111 and nidosCompletos low. `changeLevel` low for 1 cycle → nests=0, nidosCompletos high on the next cycle, lives=3 (4 with the macro defined).
- Lives out: 3 collisions → lives 2, 1, 0. PerdioVidas is low after the third and stays low while `changeLevel` is pulsed. `load` low → lives=3, PerdioVidas high.
- Simultaneous: collision and hit on free nest 2 in the same cycle → lives decrements, nests unchanged, state RESPAWN.
- Occupied nest: hit nest 1, wait out RESPAWN, hit nest 1 again → lives decrements, mask stays 5'b00010.
- Abort and ignore: `load` during RESPAWN cycle 2 → PLAY on the next cycle with lives=3. Separately, a collision during RESPAWN → ignored, lives unchanged.
